// File: rtl/storage_arbiter_if.sv
// rtl/storage_arbiter_if.sv - requester and storage-controller signal bundle for storage_arbiter
interface storage_arbiter_if #(
   parameter int MEM_W = 32
);
   logic               if_req;
   logic               if_we;
   logic [31:0]        if_addr;
   logic [MEM_W-1:0]   if_wdata;
   logic [MEM_W/8-1:0] if_be;
   logic               if_gnt;
   logic               if_rvalid;
   logic               if_err;
   logic [MEM_W-1:0]   if_rdata;

   logic               dm_req;
   logic               dm_we;
   logic [31:0]        dm_addr;
   logic [MEM_W-1:0]   dm_wdata;
   logic [MEM_W/8-1:0] dm_be;
   logic               dm_gnt;
   logic               dm_rvalid;
   logic               dm_err;
   logic [MEM_W-1:0]   dm_rdata;

   logic               st_access;
   logic               st_we;
   logic [31:0]        st_addr;
   logic [MEM_W-1:0]   st_wdata;
   logic [MEM_W/8-1:0] st_be;
   logic [MEM_W-1:0]   st_rdata;
   logic               st_done;

   // Arbiter side
   modport slave (
      input  if_req, if_we, if_addr, if_wdata, if_be,
      output if_gnt, if_rvalid, if_err, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_gnt, dm_rvalid, dm_err, dm_rdata,
      output st_access, st_we, st_addr, st_wdata, st_be,
      input  st_rdata, st_done
   );

   // Requesters and storage controller side
   modport master (
      output if_req, if_we, if_addr, if_wdata, if_be,
      input  if_gnt, if_rvalid, if_err, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_gnt, dm_rvalid, dm_err, dm_rdata,
      input  st_access, st_we, st_addr, st_wdata, st_be,
      output st_rdata, st_done
   );
endinterface

// File: rtl/storage_arbiter.sv
// rtl/storage_arbiter.sv - round-robin arbiter and sequencer sharing the storage path between fetch and data
module storage_arbiter #(
   parameter int MEM_W          = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prog_mode,
   storage_arbiter_if.slave bus,
   output logic             busy,
   output logic             timeout_flag
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t           state, state_nxt;
   logic             last_dm;   // last served requester, which is also the current owner
   logic [CNT_W-1:0] cnt;
   logic             win_dm;
   logic             grant;
   logic             done_hit;
   logic             to_hit;

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Responses and grants are gated by rst so nothing escapes during the reset cycle
   always_comb begin
      state_nxt      = state;
      grant          = 1'b0;
      done_hit       = 1'b0;
      to_hit         = 1'b0;
      win_dm         = bus.dm_req & (~bus.if_req | ~last_dm);
      bus.if_gnt     = 1'b0;
      bus.dm_gnt     = 1'b0;
      bus.if_rvalid  = 1'b0;
      bus.dm_rvalid  = 1'b0;
      bus.if_err     = 1'b0;
      bus.dm_err     = 1'b0;
      bus.if_rdata   = {MEM_W{1'b0}};
      bus.dm_rdata   = {MEM_W{1'b0}};
      bus.st_access  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rst && !prog_mode && (bus.if_req || bus.dm_req)) begin
               grant      = 1'b1;
               bus.if_gnt = ~win_dm;
               bus.dm_gnt = win_dm;
               state_nxt  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus.st_access = rst;
            state_nxt     = ST_WAIT;
         end
         ST_WAIT: begin
            done_hit = rst & bus.st_done;
            to_hit   = rst & TO_EN & ~bus.st_done & (cnt == CNT_LAST);
            if (done_hit || to_hit) state_nxt = ST_IDLE;
            bus.if_rvalid = (done_hit | to_hit) & ~last_dm;
            bus.dm_rvalid = (done_hit | to_hit) & last_dm;
            bus.if_err    = to_hit & ~last_dm;
            bus.dm_err    = to_hit & last_dm;
            if (done_hit && !last_dm) bus.if_rdata = bus.st_rdata;
            if (done_hit && last_dm)  bus.dm_rdata = bus.st_rdata;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_dm      <= 1'b0;
         cnt          <= '0;
         timeout_flag <= 1'b0;
         bus.st_we    <= 1'b0;
         bus.st_addr  <= '0;
         bus.st_wdata <= '0;
         bus.st_be    <= '0;
      end else begin
         if (grant) begin
            last_dm      <= win_dm;
            bus.st_we    <= win_dm ? bus.dm_we    : bus.if_we;
            bus.st_addr  <= win_dm ? bus.dm_addr  : bus.if_addr;
            bus.st_wdata <= win_dm ? bus.dm_wdata : bus.if_wdata;
            bus.st_be    <= win_dm ? bus.dm_be    : bus.if_be;
         end
         if (state == ST_ISSUE)     cnt <= '0;
         else if (state == ST_WAIT) cnt <= cnt + CNT_W'(1);
         if (to_hit) timeout_flag <= 1'b1;
      end
   end

   assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_storage_arbiter.sv
// tb/tb_storage_arbiter.sv - randomized scoreboard bench for storage_arbiter
module tb_storage_arbiter;
   localparam int MEM_W = 32;
   localparam int TO    = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic prog_mode = 1'b0;
   logic busy;
   logic tflag;

   storage_arbiter_if #(.MEM_W(MEM_W)) bus();

   storage_arbiter #(.MEM_W(MEM_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .prog_mode(prog_mode),
      .bus(bus.slave), .busy(busy), .timeout_flag(tflag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } resp_t;

   resp_t       exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          force_d = -1;
   bit          use_fixed_rd = 1'b0;
   logic [31:0] fixed_rd = 32'h0;
   int          cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Storage controller: latency d=1..TO completes in the d-th WAIT cycle, d=0 never completes
   initial begin : storage_model
      int          left;
      int          d;
      bit          in_txn;
      bit          never_done;
      logic [31:0] rd;
      left = 0; in_txn = 1'b0; never_done = 1'b0; rd = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            in_txn = 1'b0;
         end else if (bus.st_access) begin
            d = (force_d >= 0) ? force_d : int'($urandom_range(0, TO));
            rd = use_fixed_rd ? fixed_rd : $urandom;
            in_txn = 1'b1;
            never_done = (d == 0);
            left = never_done ? TO : d;
            if (never_done) exp_q.push_back(resp_t'{err: 1'b1, data: 32'h0, lat: TO});
            else            exp_q.push_back(resp_t'{err: 1'b0, data: rd, lat: d});
         end
         @(posedge clk); #1;
         bus.st_done = 1'b0;
         if (in_txn) begin
            left--;
            if (left == 0) begin
               in_txn = 1'b0;
               if (!never_done) begin
                  bus.st_done  = 1'b1;
                  bus.st_rdata = rd;
               end
            end
         end else if ($urandom_range(0, 3) == 0) begin
            bus.st_done  = 1'b1;
            bus.st_rdata = $urandom;
         end
      end
   end

   // Reference model: round-robin grant when idle, one outstanding transaction, response after its latency
   initial begin : monitor
      bit          open, last_dm, exp_tf, after_rst, own_dm, exp_dm, exp_g, exp_rv;
      int          gcyc;
      logic        cap_we;
      logic [31:0] cap_addr, cap_wdata;
      logic [3:0]  cap_be;
      resp_t       e;
      open = 1'b0; last_dm = 1'b0; exp_tf = 1'b0; after_rst = 1'b0; own_dm = 1'b0; gcyc = 0;
      cap_we = 1'b0; cap_addr = 32'h0; cap_wdata = 32'h0; cap_be = 4'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            chk("rst_gnt", 64'({bus.if_gnt, bus.dm_gnt}), 64'(0));
            chk("rst_rvalid", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'(0));
            chk("rst_access", 64'(bus.st_access), 64'(0));
            open = 1'b0; last_dm = 1'b0; exp_tf = 1'b0; after_rst = 1'b1;
            exp_q.delete();
         end else begin
            if (after_rst) begin
               chk("rst_st_addr", 64'(bus.st_addr), 64'(0));
               chk("rst_st_wdata", 64'(bus.st_wdata), 64'(0));
               chk("rst_ctl", 64'({busy, tflag, bus.st_we, bus.st_be}), 64'(0));
               after_rst = 1'b0;
            end
            chk("busy", 64'(busy), 64'(open));
            chk("timeout_flag", 64'(tflag), 64'(exp_tf));
            exp_g  = !open && !prog_mode && (bus.if_req || bus.dm_req);
            exp_dm = bus.dm_req && (!bus.if_req || !last_dm);
            chk("if_gnt", 64'(bus.if_gnt), 64'(exp_g && !exp_dm));
            chk("dm_gnt", 64'(bus.dm_gnt), 64'(exp_g && exp_dm));
            if (exp_g) begin
               open = 1'b1; gcyc = cyc; own_dm = exp_dm; last_dm = exp_dm;
               cap_we    = exp_dm ? bus.dm_we    : bus.if_we;
               cap_addr  = exp_dm ? bus.dm_addr  : bus.if_addr;
               cap_wdata = exp_dm ? bus.dm_wdata : bus.if_wdata;
               cap_be    = exp_dm ? bus.dm_be    : bus.if_be;
            end
            chk("st_access", 64'(bus.st_access), 64'(open && cyc == gcyc + 1));
            if (open && cyc > gcyc) begin
               chk("st_we", 64'(bus.st_we), 64'(cap_we));
               chk("st_addr", 64'(bus.st_addr), 64'(cap_addr));
               chk("st_wdata", 64'(bus.st_wdata), 64'(cap_wdata));
               chk("st_be", 64'(bus.st_be), 64'(cap_be));
            end
            exp_rv = 1'b0;
            if (open && exp_q.size() > 0)
               exp_rv = (cyc == gcyc + 1 + exp_q[0].lat);
            chk("if_rvalid", 64'(bus.if_rvalid), 64'(exp_rv && !own_dm));
            chk("dm_rvalid", 64'(bus.dm_rvalid), 64'(exp_rv && own_dm));
            if (exp_rv) begin
               e = exp_q.pop_front();
               chk("err", 64'(own_dm ? bus.dm_err : bus.if_err), 64'(e.err));
               chk("rdata", 64'(own_dm ? bus.dm_rdata : bus.if_rdata), 64'(e.data));
               if (e.err) exp_tf = 1'b1;
               open = 1'b0;
            end
         end
      end
   end

   task automatic new_if();
      bus.if_req   = 1'b1;
      bus.if_we    = 1'($urandom_range(0, 1));
      bus.if_addr  = $urandom & 32'hFFFF_FFFC;
      bus.if_wdata = $urandom;
      bus.if_be    = 4'($urandom_range(1, 15));
   endtask

   task automatic new_dm();
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_addr  = $urandom & 32'hFFFF_FFFC;
      bus.dm_wdata = $urandom;
      bus.dm_be    = 4'($urandom_range(1, 15));
   endtask

   // Requesters drop req after their grant; p_req in percent, p_prog is a toggle chance per cycle
   task automatic run(input int n, input int p_req, input int p_prog);
      logic gi, gd;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         gi = bus.if_gnt;
         gd = bus.dm_gnt;
         @(posedge clk); #1;
         if (gi) bus.if_req = 1'b0;
         if (gd) bus.dm_req = 1'b0;
         if (p_req > 0) begin
            if (!bus.if_req) begin
               if (int'($urandom_range(0, 99)) < p_req) new_if();
            end else if (p_req < 100 && $urandom_range(0, 99) < 3) bus.if_req = 1'b0;
            if (!bus.dm_req) begin
               if (int'($urandom_range(0, 99)) < p_req) new_dm();
            end else if (p_req < 100 && $urandom_range(0, 99) < 3) bus.dm_req = 1'b0;
         end
         if (p_prog > 0 && int'($urandom_range(0, 99)) < p_prog) prog_mode = !prog_mode;
      end
   endtask

   initial begin : stimulus
      bus.if_req = 1'b0; bus.if_we = 1'b0; bus.if_addr = 32'h0; bus.if_wdata = 32'h0; bus.if_be = 4'h0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0; bus.dm_be = 4'h0;
      bus.st_rdata = 32'h0; bus.st_done = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      run(2, 0, 0);

      // single read completing in the first WAIT cycle
      force_d = 1; use_fixed_rd = 1'b1; fixed_rd = 32'hDEAD_BEEF;
      bus.if_we = 1'b0; bus.if_addr = 32'h0000_0100; bus.if_be = 4'hF; bus.if_req = 1'b1;
      run(5, 0, 0);
      use_fixed_rd = 1'b0;

      // completion coincident with the timeout cycle
      force_d = TO; bus.if_addr = 32'h0000_0104; bus.if_req = 1'b1;
      run(TO + 5, 0, 0);

      // partial write, done after 5 WAIT cycles
      force_d = 5; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_3000; bus.dm_wdata = 32'h1234_5678;
      bus.dm_be = 4'b0011; bus.dm_req = 1'b1;
      run(10, 0, 0);

      // both requesting continuously
      force_d = 1;
      run(13, 100, 0);
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      run(6, 0, 0);

      // programming mode holds off a pending request
      prog_mode = 1'b1; new_if();
      run(10, 0, 0);
      prog_mode = 1'b0;
      run(5, 0, 0);

      // programming mode raised mid-transaction
      force_d = 6; new_dm();
      run(1, 0, 0);
      prog_mode = 1'b1;
      run(10, 0, 0);
      prog_mode = 1'b0;
      run(2, 0, 0);

      // hung access, then a normal one
      force_d = 0; new_if();
      run(TO + 5, 0, 0);
      force_d = 2; new_dm();
      run(6, 0, 0);

      // reset while waiting, then a tie
      force_d = 0; new_if();
      run(4, 0, 0);
      bus.if_req = 1'b0; bus.dm_req = 1'b0; rst = 1'b0;
      run(1, 0, 0);
      rst = 1'b1;
      run(1, 0, 0);
      force_d = 1; new_if(); new_dm();
      run(8, 0, 0);
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      run(4, 0, 0);

      // random traffic
      force_d = -1;
      run(3000, 35, 8);
      prog_mode = 1'b0; bus.if_req = 1'b0; bus.dm_req = 1'b0;
      run(TO + 6, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/storage_arbiter.md
# storage_arbiter

Two-port arbiter and sequencer in front of the storage controller, the single SRAM/external-SPI memory path. It shares that path between the instruction-fetch requester and the data/vector requester using round-robin order. It issues exactly one access pulse per transaction and holds the request fields stable until completion. A timeout counter keeps a hung external access from stalling the core, and the block withholds grants while programming mode is active.

## Interface
- MEM_W, 32: memory data width in bits; byte-enable width is MEM_W/8.
- TIMEOUT_CYCLES, 1024: WAIT cycles before a transaction is aborted; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset; synchronous, active-low.
- prog_mode  in  1  programming mode active; blocks new grants.
- if_req / dm_req  in  1  request, held high until granted.
- if_we / dm_we  in  1  write (1) or read (0).
- if_addr / dm_addr  in  32  byte address.
- if_wdata / dm_wdata  in  MEM_W  write data.
- if_be / dm_be  in  MEM_W/8  byte enables.
- if_gnt / dm_gnt  out  1  one-cycle grant; request fields are captured this cycle.
- if_rvalid / dm_rvalid  out  1  one-cycle completion to the owner.
- if_err / dm_err  out  1  qualifies rvalid; 1 means timeout.
- if_rdata / dm_rdata  out  MEM_W  read data, valid with rvalid.
- st_access  out  1  one-cycle access pulse to the storage controller.
- st_we  out  1  latched write flag.
- st_addr  out  32  latched address.
- st_wdata  out  MEM_W  latched write data.
- st_be  out  MEM_W/8  latched byte enables.
- st_rdata  in  MEM_W  read data from the storage controller.
- st_done  in  1  transaction complete, for both reads and writes.
- busy  out  1  state is not IDLE.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE, with prog_mode=0 and at least one request:
  - Pick the winner. A single requester wins outright. If both request, the one not served last wins.
  - Assert the winner's gnt combinationally in the same cycle.
  - Latch we/addr/wdata/be into the st_* registers, record the owner, update last_served, go to ISSUE.
- IDLE with prog_mode=1: no gnt, stay in IDLE.
- ISSUE:
  - st_access=1 for exactly this cycle.
  - Clear the timeout counter, go to WAIT.
- WAIT:
  - st_access=0; st_* fields stay stable.
  - Counter increments every cycle.
  - st_done=1: owner rvalid=1, err=0, rdata=st_rdata for writes and reads alike, go to IDLE.
  - Else if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: owner rvalid=1, err=1, rdata=0, set timeout_flag, go to IDLE.
- The non-owner never sees rvalid. gnt is never asserted outside IDLE.
- st_done outside WAIT is ignored.
- prog_mode rising during ISSUE/WAIT does not abort; the in-flight transaction completes normally.

## Timing
- Reset (rst=0 at a posedge), from any state including mid-transaction:
  - State goes to IDLE; any pending response is dropped.
  - last_served = IF, so DM wins the first tie.
  - All outputs are 0: gnt, rvalid, err, rdata, st_*, busy, timeout_flag.
  - Counter is 0.
- Minimum latency, counting the gnt cycle as cycle 0:
  - ISSUE is cycle 1.
  - Earliest rvalid is cycle 2, with st_done in the first WAIT cycle.
  - Next gnt is possible in cycle 3, giving back-to-back throughput of one transaction per 3 cycles.
- rvalid, err and rdata are combinational from st_done in WAIT. The owner must sample them the same cycle.
- st_done and timeout in the same cycle: st_done wins, err=0, timeout_flag unchanged.
- A timeout asserts rvalid in the TIMEOUT_CYCLES-th WAIT cycle, i.e. cycle TIMEOUT_CYCLES+1 after gnt.
- A requester dropping req before gnt is legal; nothing is captured.

## Test plan
- Single read:
  - Stimulus: if_req with addr=0x0000_0100; model returns st_done in the 1st WAIT cycle with st_rdata=0xDEADBEEF.
  - Required: if_gnt at cycle 0, st_access only at cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF and if_err=0 at cycle 2; dm_rvalid stays 0.
- Tie and alternation:
  - Stimulus: after reset, if_req and dm_req held high continuously.
  - Required: grants go DM, IF, DM, IF, each 3 cycles apart; st_addr matches the granted requester.
- Write with byte enables:
  - Stimulus: dm write, addr=0x0000_3000, wdata=0x1234_5678, be=4'b0011; st_done after 5 WAIT cycles.
  - Required: st_we=1 and st_be=0011, all st_* fields stable for all 5 WAIT cycles; dm_rvalid=1 with dm_err=0 on the done cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, st_done never asserted.
  - Required: rvalid with err=1 and rdata=0 at cycle 9 after gnt; timeout_flag stays 1; the next request is served normally.
  - Also: st_done coincident with cycle 9 gives err=0 and timeout_flag stays 0.
- Programming mode:
  - Stimulus: prog_mode=1 while if_req is held.
  - Required: no gnt for the entire assertion; gnt occurs in the first cycle after prog_mode drops.
  - Also: prog_mode raised during WAIT still lets that transaction complete.
- Reset mid-WAIT:
  - Stimulus: rst=0 for 1 cycle while in WAIT, then st_done arrives.
  - Required: all outputs 0 after the edge, no rvalid for the dropped transaction, busy=0, and a subsequent tie is granted to DM.
